uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
- Parametrised full-duplex UART, successor to the fixed 8N1 / 115200-at-50MHz UART used for host image and weight download and result upload on the DE0-Nano CNN design.
- Generalises the baud divisor, data width, parity mode and stop-bit count.
- Adds mid-start-bit false-start rejection, framing and parity error flags, overrun detection, break-safe receiver re-arm and a tx_busy status.
- Sits between the board UART pins and the command/packet controller.

Parameters:
- CLK_DIV, 434: clk cycles per bit. Must be ≥ 8. CLK_DIV/2 uses integer division.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2. Affects TX only; RX checks only the first stop bit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- RX  in  1  serial input, asynchronous to clk
- TX  out  1  serial output
- trmt  in  1  single-cycle pulse: start transmitting tx_data
- tx_data  in  DATA_BITS  byte to send; sampled only on the cycle trmt is accepted
- tx_busy  out  1  transmitter mid-frame
- tx_done  out  1  last frame complete; sticky
- rx_data  out  DATA_BITS  last received word, LSB = first data bit received
- rx_rdy  out  1  new word available; sticky
- clr_rx_rdy  in  1  clears rx_rdy and overrun
- parity_err  out  1  parity mismatch in the last frame (always 0 when PARITY = 0)
- framing_err  out  1  first stop bit sampled low in the last frame
- overrun  out  1  a frame completed while rx_rdy was still set

Behaviour:
Reset: one clock, synchronous, active-high; the only reset in the block.
- While asserted: TX=1, tx_busy=0, tx_done=0, rx_rdy=0, rx_data=0, all error flags 0, both synchroniser flops 1, both FSMs in IDLE.
- Reset mid-frame aborts the frame; TX is 1 on the first cycle after rst deasserts.

Transmitter FSM, states IDLE → TX_SHIFT → IDLE:
- trmt in IDLE is accepted: tx_data is latched, tx_busy=1 and tx_done=0 from the next cycle.
- TX drives the start bit (0) starting the cycle after trmt.
- Frame order: start, DATA_BITS data bits LSB first, parity bit if PARITY≠0, then STOP_BITS stop bits (1). Each bit is held exactly CLK_DIV cycles.
- Even parity = XOR of the data bits; odd parity = its inverse.
- When the final stop bit's CLK_DIV cycles expire: tx_busy=0 and tx_done=1 on the same cycle, FSM returns to IDLE.
- tx_done stays set until the next accepted trmt.
- trmt while tx_busy=1 is ignored; the frame in progress is not disturbed.
- trmt on the cycle tx_busy falls is accepted. This gives back-to-back frames with no idle gap.

Receiver FSM, states IDLE → START_CHK → RX_SHIFT → STOP_WAIT → IDLE:
- RX passes through a 2-flop synchroniser; rxs is the synchronised value.
- IDLE: rxs=0 → START_CHK, half-bit counter loaded with CLK_DIV/2.
- START_CHK: when the counter expires, sample rxs.
  - rxs=1: false start. Return to IDLE; no flag or output changes.
  - rxs=0: go to RX_SHIFT; bit counter loaded with CLK_DIV.
- RX_SHIFT: sample rxs every CLK_DIV cycles. Sample count is DATA_BITS, plus 1 if parity is enabled, plus 1 for the stop bit.
- On the cycle after the stop-bit sample (frame completion):
  - rx_data updated, rx_rdy=1.
  - parity_err and framing_err rewritten for this frame.
  - rx_rdy is set even when errors are present.
  - Frame with stop=1: go to IDLE immediately, half a bit early, so the receiver re-arms for the next start bit.
  - Frame with stop=0 (framing error / break): go to STOP_WAIT, which holds until rxs=1, then IDLE. A held break therefore produces exactly one frame.
- Overrun: frame completes while rx_rdy=1 and clr_rx_rdy=0 → overrun=1 (sticky) and rx_data is overwritten.
- clr_rx_rdy clears rx_rdy and overrun.
- clr_rx_rdy on the completion cycle: the set wins. rx_rdy stays 1 and overrun does not set.
- Latency from the RX falling edge to rx_rdy rising: 2 + CLK_DIV/2 + (DATA_BITS + (PARITY≠0) + 1)·CLK_DIV + 1 cycles, ±1.

Independence: TX and RX are fully independent. Simultaneous transmit and receive is legal.

Test Plan:
- CLK_DIV=16, 8N1; TX looped back to RX. Pulse trmt with tx_data=0xA5 → TX low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high; tx_done at cycle 161 after trmt; rx_rdy with rx_data=0xA5 and no error flags.
- CLK_DIV=16, PARITY=1, STOP_BITS=2: send 0x07 → parity bit 1 and 2 stop bits, tx_done after 192 cycles. Bench drives RX with a corrupted parity bit → parity_err=1, rx_data=0x07, rx_rdy=1.
- RX low for 5 cycles only (less than CLK_DIV/2) → no rx_rdy, no flags, receiver back in IDLE and correctly receives the following 0x3C.
- RX held low for 30 bit-times (break) → exactly one frame: rx_data=0x00, framing_err=1. No second rx_rdy until RX has returned high and a new start bit is seen.
- Two frames 0x11 then 0x22 without clr_rx_rdy → rx_data=0x22, overrun=1. Then clr_rx_rdy → rx_rdy=0, overrun=0. Repeat with clr_rx_rdy on the completion cycle → rx_rdy=1, overrun=0.
- Assert rst for 1 cycle mid-TX-frame and mid-RX-frame → TX=1, tx_busy=0, rx_rdy=0 the next cycle. A trmt with 0x5A 2 cycles later produces a clean, correct frame.

Source files
------------

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: TX frame starts the cycle after an accepted trmt; RX flags a word
// about (CLK_DIV/2 + frame bits*CLK_DIV + 3) clocks after the start edge. No backpressure; overrun is flagged.
module uart_cfg #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic                 TX,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  input  logic                 clr_rx_rdy,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int PW  = (PARITY != 0) ? 1 : 0;
  localparam int TXN = 1 + DATA_BITS + PW + STOP_BITS;
  localparam int RXW = DATA_BITS + PW;
  localparam int RXN = RXW + 1;
  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int TBW = $clog2(TXN + 1);
  localparam int RBW = $clog2(RXN + 1);

  localparam logic [CW-1:0] DIV_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  localparam logic [1:0] RX_IDLE      = 2'd0;
  localparam logic [1:0] RX_START_CHK = 2'd1;
  localparam logic [1:0] RX_SHIFT     = 2'd2;
  localparam logic [1:0] RX_STOP_WAIT = 2'd3;

  // ---------------------------------------------------------------- transmitter
  logic [0:0]     tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [TBW-1:0] tx_bit;
  logic [TXN-2:0] tx_sh;
  logic           tx_q;
  logic           tx_done_q;
  logic [TXN-1:0] tx_frame;
  logic           tx_par;
  logic           tx_bit_end;
  logic           tx_last_bit;

  always_comb begin
    tx_par                 = (^tx_data) ^ (PARITY == 2);
    tx_frame               = '1;
    tx_frame[0]            = 1'b0;
    tx_frame[DATA_BITS:1]  = tx_data;
    tx_frame[DATA_BITS+1]  = (PW != 0) ? tx_par : 1'b1;
  end

  assign tx_bit_end  = (tx_cnt == DIV_LAST);
  assign tx_last_bit = (tx_bit == TBW'(TXN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_state  <= TX_SHIFT;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= tx_frame[TXN-1:1];
            tx_q      <= tx_frame[0];
            tx_done_q <= 1'b0;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_last_bit) begin
              tx_state  <= TX_IDLE;
              tx_q      <= 1'b1;
              tx_done_q <= 1'b1;
            end else begin
              // Remaining frame bits sit LSB-first; refill with idle-high
              tx_bit <= tx_bit + TBW'(1);
              tx_q   <= tx_sh[0];
              tx_sh  <= {1'b1, tx_sh[TXN-2:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign TX      = tx_q;
  assign tx_busy = (tx_state == TX_SHIFT);
  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------- receiver
  logic           rx_meta;
  logic           rxs;
  logic [1:0]     rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [RBW-1:0] rx_bit;
  logic [RXW-1:0] rx_sh;
  logic           rx_cnt_exp;
  logic           rx_last;
  logic           rx_complete;
  logic           rx_exp_par;
  logic           rx_perr;

  assign rx_cnt_exp  = (rx_cnt == CNT_ONE);
  assign rx_last     = (rx_bit == RBW'(RXN - 1));
  assign rx_complete = (rx_state == RX_SHIFT) && rx_cnt_exp && rx_last;
  assign rx_exp_par  = (^rx_sh[DATA_BITS-1:0]) ^ (PARITY == 2);
  assign rx_perr     = (PW != 0) && (rx_sh[RXW-1] != rx_exp_par);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START_CHK;
            rx_cnt   <= DIV_HALF;
          end
        end
        RX_START_CHK: begin
          if (rx_cnt_exp) begin
            if (rxs) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_SHIFT;
              rx_cnt   <= DIV_FULL;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        RX_SHIFT: begin
          if (rx_cnt_exp) begin
            rx_cnt <= DIV_FULL;
            if (rx_last) begin
              rx_data     <= rx_sh[DATA_BITS-1:0];
              parity_err  <= rx_perr;
              framing_err <= !rxs;
              // A low stop bit may be a break: wait for the line to go idle first
              rx_state    <= rxs ? RX_IDLE : RX_STOP_WAIT;
            end else begin
              rx_sh  <= {rxs, rx_sh[RXW-1:1]};
              rx_bit <= rx_bit + RBW'(1);
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        default: begin
          if (rxs) begin
            rx_state <= RX_IDLE;
          end
        end
      endcase
    end
  end

  // A completing frame outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rdy  <= 1'b0;
      overrun <= 1'b0;
    end else if (rx_complete) begin
      rx_rdy  <= 1'b1;
      overrun <= clr_rx_rdy ? 1'b0 : (overrun | rx_rdy);
    end else if (clr_rx_rdy) begin
      rx_rdy  <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: 8N1 instance (loopback capable) and 8E2 instance, CLK_DIV=16.
module tb_uart_cfg;
  localparam int DIV = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx0, tx0, trmt0, busy0, done0, rdy0, clr0, pe0, fe0, ov0;
  logic [7:0] txd0, rxd0;
  logic       rx1, tx1, trmt1, busy1, done1, rdy1, clr1, pe1, fe1, ov1;
  logic [7:0] txd1, rxd1;

  logic loop0 = 1'b0;
  logic rx_drv0 = 1'b1;
  logic rx_drv1 = 1'b1;
  logic clr_mon0 = 1'b0;
  logic clr_mon1 = 1'b0;
  logic clr_tb0 = 1'b0;
  logic auto_clr = 1'b1;

  assign rx0  = loop0 ? tx0 : rx_drv0;
  assign rx1  = rx_drv1;
  assign clr0 = clr_mon0 | clr_tb0;
  assign clr1 = clr_mon1;

  uart_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .RX(rx0), .TX(tx0), .trmt(trmt0), .tx_data(txd0),
    .tx_busy(busy0), .tx_done(done0), .rx_data(rxd0), .rx_rdy(rdy0),
    .clr_rx_rdy(clr0), .parity_err(pe0), .framing_err(fe0), .overrun(ov0)
  );

  uart_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .RX(rx1), .TX(tx1), .trmt(trmt1), .tx_data(txd1),
    .tx_busy(busy1), .tx_done(done1), .rx_data(rxd1), .rx_rdy(rdy1),
    .clr_rx_rdy(clr1), .parity_err(pe1), .framing_err(fe1), .overrun(ov1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Monitors: pop one expected word per rising rx_rdy
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  always @(negedge clk) begin : mon0
    exp_t e;
    clr_mon0 = 1'b0;
    if (rdy0 && !prev0) begin
      check("sb0_pending", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("rx0_data", rxd0, e.d);
        check("rx0_parity_err", pe0, e.pe);
        check("rx0_framing_err", fe0, e.fe);
      end
      if (auto_clr) clr_mon0 = 1'b1;
    end
    prev0 = rdy0;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    clr_mon1 = 1'b0;
    if (rdy1 && !prev1) begin
      check("sb1_pending", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("rx1_data", rxd1, e.d);
        check("rx1_parity_err", pe1, e.pe);
        check("rx1_framing_err", fe1, e.fe);
      end
      if (auto_clr) clr_mon1 = 1'b1;
    end
    prev1 = rdy1;
  end

  task automatic drive_rx(input int inst, input logic b);
    if (inst == 0) rx_drv0 = b;
    else rx_drv1 = b;
  endtask

  // Serial frame onto RX; called at a negedge, returns at a negedge
  task automatic send(input int inst, input logic [7:0] d, input logic par_en,
                      input logic par_bit, input logic stop);
    logic [11:0] bits;
    int n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (par_en) begin
      bits[9]  = par_bit;
      bits[10] = stop;
      n = 11;
    end else begin
      bits[9] = stop;
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      drive_rx(inst, bits[i]);
      repeat (DIV) @(negedge clk);
    end
    drive_rx(inst, 1'b1);
  endtask

  // Pulse trmt and compare TX against a hand-computed LSB-first frame image
  task automatic tx_frame_chk(input int inst, input logic [7:0] d, input logic [15:0] fr, input int nb);
    int bad_tx;
    int bad_busy;
    logic t, b, dn;
    bad_tx   = 0;
    bad_busy = 0;
    if (inst == 0) begin trmt0 = 1'b1; txd0 = d; end
    else begin trmt1 = 1'b1; txd1 = d; end
    for (int c = 1; c <= nb * DIV + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin trmt0 = 1'b0; trmt1 = 1'b0; end
      t  = (inst == 0) ? tx0 : tx1;
      b  = (inst == 0) ? busy0 : busy1;
      dn = (inst == 0) ? done0 : done1;
      if (c <= nb * DIV) begin
        if (t !== fr[(c - 1) / DIV]) bad_tx++;
        if (b !== 1'b1) bad_busy++;
      end
      if (c == nb * DIV) check("tx_done_early", dn, 0);
      if (c == nb * DIV + 1) begin
        check("tx_busy_end", b, 0);
        check("tx_done_set", dn, 1);
      end
    end
    check("tx_wave_bad_cycles", bad_tx, 0);
    check("tx_busy_bad_cycles", bad_busy, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("sb_drain_left", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    trmt0 = 1'b0; trmt1 = 1'b0;
    txd0  = 8'h00; txd1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rdy", rdy0, 0);
    check("rst_rx_data", rxd0, 0);
    check("rst_flags", {pe0, fe0, ov0}, 0);
    check("rst_tx1", tx1, 1);
    check("rst_rdy1", rdy1, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 loopback 0xA5: frame {1,A5,0}
    loop0 = 1'b1;
    q0.push_back(mk(8'hA5, 1'b0, 1'b0));
    tx_frame_chk(0, 8'hA5, 16'h034A, 10);
    wait_drain();
    check("a5_overrun", ov0, 0);
    loop0 = 1'b0;

    // 8E2 0x07: parity 1, two stops; then RX with corrupted parity
    tx_frame_chk(1, 8'h07, 16'h0E0E, 12);
    q1.push_back(mk(8'h07, 1'b1, 1'b0));
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // 5-cycle glitch is rejected, then a clean 0x3C
    rx_drv0 = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv0 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rdy", rdy0, 0);
    check("glitch_flags", {pe0, fe0}, 0);
    q0.push_back(mk(8'h3C, 1'b0, 1'b0));
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // 30 bit-time break: one frame of zeros with framing error
    q0.push_back(mk(8'h00, 1'b0, 1'b1));
    rx_drv0 = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    check("break_single_rdy", rdy0, 0);
    check("break_framing", fe0, 1);
    check("break_frames_left", q0.size(), 0);
    rx_drv0 = 1'b1;
    repeat (20) @(negedge clk);
    q0.push_back(mk(8'h55, 1'b0, 1'b0));
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Overrun, then clear; then clear landing on the completion cycle
    auto_clr = 1'b0;
    q0.push_back(mk(8'h11, 1'b0, 1'b0));
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check("ovr_data", rxd0, 8'h22);
    check("ovr_rdy", rdy0, 1);
    check("ovr_set", ov0, 1);
    clr_tb0 = 1'b1;
    @(negedge clk);
    clr_tb0 = 1'b0;
    check("clr_rdy", rdy0, 0);
    check("clr_ovr", ov0, 0);
    q0.push_back(mk(8'h33, 1'b0, 1'b0));
    send(0, 8'h33, 1'b0, 1'b0, 1'b1);
    fork
      send(0, 8'h44, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(negedge clk);
        clr_tb0 = 1'b1;
        @(negedge clk);
        clr_tb0 = 1'b0;
      end
    join
    check("clr_race_rdy", rdy0, 1);
    check("clr_race_ovr", ov0, 0);
    check("clr_race_data", rxd0, 8'h44);

    // Reset mid TX and mid RX frame, then a clean 0x5A
    loop0 = 1'b1;
    trmt0 = 1'b1;
    txd0  = 8'h99;
    @(negedge clk);
    trmt0 = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_rdy", rdy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_rx_data", rxd0, 0);
    auto_clr = 1'b1;
    @(negedge clk);
    q0.push_back(mk(8'h5A, 1'b0, 1'b0));
    tx_frame_chk(0, 8'h5A, 16'h02B4, 10);
    wait_drain();
    check("post_rst_overrun", ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
